wb_regfile: RTL
===============

Name: wb_regfile

Overview:
Writeback stage of the 5-stage pipelined RV32I core, sitting directly downstream of the MEM/WB pipeline register. It selects the writeback result from the W-stage operands and commits it to the 32-entry integer register file. It also serves the two decode-stage read ports. ResultW is exported so the hazard/forwarding unit can bypass it into EX.

Parameters:
XLEN, 32, data width of registers and result operands
NREG, 32, number of architectural registers; address width is clog2(NREG), 5 at default

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
RegWriteW  input  1  write enable from the MEM/WB register
ResultSrcW  input  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ExtImmW
RdW  input  5  destination register index
ALUResultW  input  XLEN  ALU result
ReadDataW  input  XLEN  data memory load value
ExtImmW  input  XLEN  extended immediate (LUI)
PCPlus4W  input  XLEN  link value (JAL/JALR)
A1  input  5  decode read address, port 1 (rs1)
A2  input  5  decode read address, port 2 (rs2)
RD1  output  XLEN  read data, port 1
RD2  output  XLEN  read data, port 2
ResultW  output  XLEN  selected writeback value, to the forwarding muxes

Behaviour:
- rst=0, asynchronous: all NREG registers are cleared to 0 immediately, with no clock needed. While rst=0, RD1 and RD2 read 0.
- ResultW is purely combinational from ResultSrcW and the four operands, per the encoding above. It has no latency and is valid during reset.
- Write: on a rising clk with rst=1, RegWriteW=1 and RdW!=0, reg[RdW] takes ResultW. The new value is visible at the read ports from the next cycle; same-cycle visibility is covered under the optional feature.
- x0 is hardwired: writes with RdW=0 are dropped, and reads of A1/A2=0 return 0 regardless of any pending write.
- Reads are asynchronous and combinational from A1/A2. Both ports may read the same register.
- RegWriteW=0 leaves all registers unchanged, whatever RdW and ResultSrcW are.
- Reset deasserting mid-stream: the first rising edge after rst rises commits normally. No write may occur while rst=0; an edge coinciding with rst=0 is ignored.
- Upper bits: XLEN operands are passed through unmodified. There is no extension in this block.

Optional Feature:
Macro: WB_REGFILE_BYPASS_EN
- Defined: internal write-first bypass. If RegWriteW=1, RdW!=0 and A1==RdW, then RD1=ResultW in the same cycle, and likewise for A2/RD2. The x0 rule takes priority over the bypass.
- Undefined: read ports return only the stored contents, so a same-cycle write is seen on the next cycle. The hazard unit must stall decode for one cycle on a W-to-D dependence.

Decomposition:
- Shared package riscv_pkg holds:
  - the ResultSrc encoding constants: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11
  - XLEN
  - REG_ADDR_W=5
- One sub-module, wb_result_mux: a 4:1 XLEN-wide result select. Register storage and the read/bypass logic stay in the top module.

Test Plan:
- Reset: drive rst=0 mid-run after writing reg5=0xDEADBEEF -> RD1 (A1=5) reads 0 immediately, with no clock edge.
- Result select: ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33, ExtImmW=0x44, sweep ResultSrcW 00..11 -> ResultW = 0x11, 0x22, 0x33, 0x44.
- Write/read: RegWriteW=1, RdW=7, ResultSrcW=01, ReadDataW=0xCAFEF00D, one edge -> RD2 (A2=7) = 0xCAFEF00D; a following cycle with RegWriteW=0 and RdW=7 leaves it unchanged.
- x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFFFFFF, edge -> RD1 (A1=0) = 0; with the bypass feature on, reading A1=0 during that write is still 0.
- Same-cycle hazard: reg3=0x1, then write 0x2 to reg3 with A1=A2=3 sampled before the edge -> RD1=RD2=0x2 with WB_REGFILE_BYPASS_EN defined, and 0x1 without it; both read 0x2 after the edge.
- Async reset during write: rst falls while RegWriteW=1 and RdW=9, then rises, then 1 edge with RegWriteW=0 -> reg9=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, register address width and
// the writeback result-select encoding.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

endpackage : riscv_pkg

// File: rtl/wb_result_mux.sv
// Writeback result select: picks the W-stage value to commit and forward.
module wb_result_mux #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      resultSrc,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] readData,
  input  logic [XLEN-1:0] pcPlus4,
  input  logic [XLEN-1:0] extImm,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  always_comb begin
    result = aluResult;
    case (resultSrc)
      RES_ALU: result = aluResult;
      RES_MEM: result = readData;
      RES_PC4: result = pcPlus4;
      RES_IMM: result = extImm;
      default: result = aluResult;
    endcase
  end

endmodule : wb_result_mux

// File: rtl/wb_regfile.sv
// Writeback stage plus the integer register file (x0 hardwired to zero).
// Define WB_REGFILE_BYPASS_EN for write-first reads of a same-cycle write.
module wb_regfile #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            RegWriteW,
  input  logic [1:0]                      ResultSrcW,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]                 ALUResultW,
  input  logic [XLEN-1:0]                 ReadDataW,
  input  logic [XLEN-1:0]                 ExtImmW,
  input  logic [XLEN-1:0]                 PCPlus4W,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] A1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] A2,
  output logic [XLEN-1:0]                 RD1,
  output logic [XLEN-1:0]                 RD2,
  output logic [XLEN-1:0]                 ResultW
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic            wrEn;

  wb_result_mux #(.XLEN(XLEN)) uResultMux (
    .resultSrc (ResultSrcW),
    .aluResult (ALUResultW),
    .readData  (ReadDataW),
    .pcPlus4   (PCPlus4W),
    .extImm    (ExtImmW),
    .result    (ResultW)
  );

  // x0 writes are dropped here so the storage for x0 never leaves zero
  assign wrEn = RegWriteW && (RdW != '0) && (32'(RdW) < NREG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[RdW] <= ResultW;
    end
  end

  // Read ports: x0 and reset force zero ahead of storage and bypass
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (rst && (A1 != '0) && (32'(A1) < NREG)) begin
      RD1 = regs[A1];
`ifdef WB_REGFILE_BYPASS_EN
      if (wrEn && (A1 == RdW)) RD1 = ResultW;
`endif
    end
    if (rst && (A2 != '0) && (32'(A2) < NREG)) begin
      RD2 = regs[A2];
`ifdef WB_REGFILE_BYPASS_EN
      if (wrEn && (A2 == RdW)) RD2 = ResultW;
`endif
    end
  end

endmodule : wb_regfile
